div_unit: RTL
=============

# div_unit

Multi-cycle 32-bit integer divider that serves the execute stage's DIV/DIVU requests, using radix-2 restoring division over 32 iterations. The execute stage issues operands with `start_i` and stalls the pipeline until `ready_o` is high. It then forwards `result_o` to HI/LO over its existing `whilo_o/hi_o/lo_o` path: HI receives the remainder and LO the quotient.

## Interface
- No parameters; the datapath is fixed at 32 bits.
- `clk`  in  1  — sole clock; all state updates on the rising edge.
- `rst`  in  1  — asynchronous, active-low reset.
- `signed_div_i`  in  1  — 1 = DIV (two's complement), 0 = DIVU.
- `opdata1_i`  in  32  — dividend; sampled when a request is accepted.
- `opdata2_i`  in  32  — divisor; sampled when a request is accepted.
- `start_i`  in  1  — request. Held high by the execute stage until it has consumed `ready_o`.
- `annul_i`  in  1  — abort: flush or exception on the owning instruction.
- `result_o`  out  64  — {remainder[63:32], quotient[31:0]}; registered.
- `ready_o`  out  1  — result valid; registered.

## Operation
- **FSM states:** FREE, BYZERO, ON, END. Reset state is FREE, with `result_o`=0, `ready_o`=0 and the iteration counter `cnt`=0.
- **FREE**
  - Accepts a request when `start_i`=1 and `annul_i`=0.
  - If `opdata2_i`=0, goes to BYZERO.
  - Otherwise latches the operand magnitudes, clears the partial remainder and `cnt`, and goes to ON.
  - Magnitude = two's-complement negate when `signed_div_i`=1 and bit 31 is set; otherwise the raw value.
  - Also latches the dividend sign and the quotient sign (dividend sign XOR divisor sign). Both signs are 0 for DIVU.
- **BYZERO:** loads `result_o`=64'h0, sets `ready_o`=1, goes to END.
- **ON, one iteration per cycle while `cnt`<32:**
  - {rem, dvd} shifts left by 1; trial = rem − divisor magnitude (33-bit subtract).
  - If trial is non-negative: rem = trial and the quotient LSB = 1. Otherwise rem is kept and the LSB = 0.
  - `cnt` increments.
- **ON, `cnt`=32 (finalize):**
  - Quotient is negated if the quotient sign is set; remainder is negated if the dividend sign is set. The remainder therefore takes the dividend's sign.
  - Loads `result_o`, sets `ready_o`=1, goes to END.
- **END:** holds `result_o` and `ready_o`=1 while `start_i`=1. When `start_i`=0: goes to FREE, `ready_o`=0, `result_o`=0.
- **Annul:** `annul_i`=1 in ON or BYZERO returns the FSM to FREE on the next edge. `ready_o` stays 0 and `result_o` stays 0. In END, annul has no effect; `start_i` governs exit.
- **Overflow case:** 0x80000000 / 0xFFFFFFFF signed gives quotient 0x80000000, remainder 0. No trap is raised.
- **Divide by zero** is UNPREDICTABLE architecturally; this block defines the result as 0/0.

## Timing
- Edge E0 accepts the request.
- Normal path:
  - Edges E1–E32 perform the 32 iterations.
  - Edge E33 registers the result; `ready_o` is high after E33, a latency of 33 cycles.
- Divide-by-zero path: `ready_o` is high after E1.
- Back-to-back requests: `start_i` must be low for at least one edge (END→FREE) before a new request can be accepted. The earliest new acceptance is the edge after the exit from END.
- Reset asserted mid-operation: asynchronously forces FREE with all outputs 0. Any in-flight division is discarded.
- Operands are not resampled after E0. Changes on `opdata*_i` during ON are ignored.

## Configuration
- **`DIV_EARLY_OUT_EN`**
  - Defined: in FREE, with a non-zero divisor and dividend magnitude < divisor magnitude (unsigned compare), E0 goes directly to END. It loads `result_o`={original `opdata1_i`, 32'h0} and `ready_o`=1, so `ready_o` is high after E0.
  - Undefined: every non-zero-divisor request takes the full 33-cycle path.
  - Result values are identical in both builds.

## Test plan
- **DIVU 100/7:** `start_i`=1, `signed_div_i`=0 → `ready_o` rises after E33, `result_o`=64'h00000002_0000000E. It holds until `start_i`=0, then `result_o`=0 and `ready_o`=0 on the next edge.
- **DIV −7/2 (0xFFFFFFF9, 0x00000002):** → `result_o`=64'hFFFFFFFF_FFFFFFFD. Also DIV 7/−2 → 64'h00000001_FFFFFFFD.
- **DIV 0x80000000/0xFFFFFFFF** → `result_o`=64'h00000000_80000000. **DIVU 5/0** → `ready_o` high after E1, `result_o`=0.
- **Abort and reset:**
  - `annul_i` pulsed at E10 of a DIVU 1000/3 → FREE after E10, `ready_o` never asserts. A new request at E12 then completes with 64'h00000001_0000014D.
  - `rst` low at E20 → all outputs 0 immediately.
- **`DIV_EARLY_OUT_EN` defined, DIVU 3/10:**
  - → `ready_o` high after E0, `result_o`=64'h00000003_00000000.
  - Same stimulus with the macro undefined → same value after E33.

Source files
------------

// File: rtl/div_unit.sv
// Multi-cycle 32-bit radix-2 restoring divider (DIV/DIVU) for the execute stage.
// Optional build macro DIV_EARLY_OUT_EN: skip iteration when |dividend| < |divisor|.
module div_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {FREE, BYZERO, ON, END} state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic [31:0] rem;
  logic [31:0] quo;
  logic [31:0] dvs;
  logic        sign_r;
  logic        sign_q;

  function automatic logic [31:0] neg_if(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

  logic signed [31:0] op1_s;
  logic signed [31:0] op2_s;
  logic        sgn1;
  logic        sgn2;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic        accept;
  logic        early;
  logic [32:0] shifted;
  logic [32:0] trial;

  assign op1_s  = opdata1_i;
  assign op2_s  = opdata2_i;
  assign sgn1   = signed_div_i & (op1_s < 0);
  assign sgn2   = signed_div_i & (op2_s < 0);
  assign mag1   = neg_if(sgn1, opdata1_i);
  assign mag2   = neg_if(sgn2, opdata2_i);
  assign accept = (state == FREE) && start_i && !annul_i;

`ifdef DIV_EARLY_OUT_EN
  assign early = (mag1 < mag2);
`else
  assign early = 1'b0;
`endif

  // Trial subtraction on the shifted {rem, quo} pair; bit 32 set means it went negative
  assign shifted = {rem, quo[31]};
  assign trial   = shifted - {1'b0, dvs};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= FREE;
      cnt      <= 6'd0;
      result_o <= 64'h0;
      ready_o  <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (accept) begin
            if (opdata2_i == 32'h0) begin
              state <= BYZERO;
            end else if (early) begin
              result_o <= {opdata1_i, 32'h0};
              ready_o  <= 1'b1;
              state    <= END;
            end else begin
              cnt   <= 6'd0;
              state <= ON;
            end
          end
        end
        BYZERO: begin
          if (annul_i) begin
            state <= FREE;
          end else begin
            result_o <= 64'h0;
            ready_o  <= 1'b1;
            state    <= END;
          end
        end
        ON: begin
          if (annul_i) begin
            state <= FREE;
          end else if (cnt == 6'd32) begin
            result_o <= {neg_if(sign_r, rem), neg_if(sign_q, quo)};
            ready_o  <= 1'b1;
            state    <= END;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        END: begin
          if (!start_i) begin
            result_o <= 64'h0;
            ready_o  <= 1'b0;
            state    <= FREE;
          end
        end
        default: state <= FREE;
      endcase
    end
  end

  // Datapath registers carry no reset; they are always loaded on acceptance
  always_ff @(posedge clk) begin
    if (accept) begin
      rem    <= 32'h0;
      quo    <= mag1;
      dvs    <= mag2;
      sign_r <= sgn1;
      sign_q <= sgn1 ^ sgn2;
    end else if ((state == ON) && (cnt < 6'd32)) begin
      rem <= trial[32] ? shifted[31:0] : trial[31:0];
      quo <= {quo[30:0], ~trial[32]};
    end
  end

endmodule
